// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM and slot states,
// operation encoding and the captured-request record.
package mem_arb_pkg;

  localparam int NUM_M = 2;
  localparam int DW    = 64;
  localparam int TW    = 8;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WAIT,
    ST_DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_ADDR_HELD,
    SLOT_PENDING
  } slot_state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [TW-1:0] tag;
    logic [DW-1:0] wdata;
    logic [TW-1:0] wtag;
    op_e           op;
  } slot_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the master-side request/response signals and the slave-side bus.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic [NUM_M-1:0][DW-1:0] m_ad;
  logic [NUM_M-1:0][TW-1:0] m_tag;
  logic [NUM_M-1:0]         m_astb;
  logic [NUM_M-1:0]         m_rd;
  logic [NUM_M-1:0]         m_wr;
  logic [DW-1:0]            m_data;
  logic [TW-1:0]            m_dtag;
  logic [NUM_M-1:0]         m_done;
  logic [NUM_M-1:0]         m_err;

  logic [DW-1:0]            s_ad;
  logic [TW-1:0]            s_tag;
  logic                     s_astb;
  logic                     s_rd;
  logic                     s_wr;
  logic [DW-1:0]            s_data;
  logic [TW-1:0]            s_dtag;
  logic                     s_rdy;

  // The arbiter itself: serves the masters, drives the slave bus.
  modport arb (
    input  m_ad, m_tag, m_astb, m_rd, m_wr, s_data, s_dtag, s_rdy,
    output m_data, m_dtag, m_done, m_err, s_ad, s_tag, s_astb, s_rd, s_wr
  );

  modport master (
    output m_ad, m_tag, m_astb, m_rd, m_wr,
    input  m_data, m_dtag, m_done, m_err
  );

  modport slave (
    input  s_ad, s_tag, s_astb, s_rd, s_wr,
    output s_data, s_dtag, s_rdy
  );

endinterface

// File: rtl/mem_arb_slot.sv
// Per-master request capture: address cycle, then op/write-data cycle, then
// held as pending until the arbiter frees it in its DONE cycle.
module mem_arb_slot
  import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          astb,
    input  logic          rd,
    input  logic          wr,
    input  logic [DW-1:0] ad,
    input  logic [TW-1:0] tag,
    input  logic          free,
    output logic          pending,
    output slot_t         req,
    output logic          err
);

    slot_state_e state;

    assign pending = (state == SLOT_PENDING);

    // Strobe on an occupied slot or a contradictory rd+wr both flag an error.
    assign err = (astb && (state != SLOT_EMPTY)) ||
                 ((state == SLOT_ADDR_HELD) && rd && wr);

    // NOTE: state and payload update with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SLOT_EMPTY;
            // NOTE: the payload is reset too; it is small and keeps the slave bus X-free.
            req   <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (astb) begin
                        req.addr <= ad;
                        req.tag  <= tag;
                        state    <= SLOT_ADDR_HELD;
                    end
                end
                SLOT_ADDR_HELD: begin
                    if (rd == wr) begin
                        state <= SLOT_EMPTY;
                    end else if (rd) begin
                        req.op <= OP_RD;
                        state  <= SLOT_PENDING;
                    end else begin
                        req.op    <= OP_WR;
                        req.wdata <= ad;
                        req.wtag  <= tag;
                        state     <= SLOT_PENDING;
                    end
                end
                SLOT_PENDING: begin
                    if (free) state <= SLOT_EMPTY;
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single address/data slave bus with a
// bounded wait for slave completion.
module mem_arbiter
  import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input logic      clk,
    input logic      reset,
    mem_arbiter_if.arb bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    arb_state_e       state;
    logic             grant;
    logic             last;
    logic             timed_out;
    logic [CNT_W-1:0] cnt;

    logic             gnt;
    logic [NUM_M-1:0] pend;
    logic [NUM_M-1:0] slot_err;
    logic [NUM_M-1:0] free;
    slot_t            slot_req [NUM_M];
    slot_t            cur;

    for (genvar i = 0; i < NUM_M; i++) begin : g_slot
        mem_arb_slot u_slot (
            .clk     (clk),
            .reset   (reset),
            .astb    (bus.m_astb[i]),
            .rd      (bus.m_rd[i]),
            .wr      (bus.m_wr[i]),
            .ad      (bus.m_ad[i]),
            .tag     (bus.m_tag[i]),
            .free    (free[i]),
            .pending (pend[i]),
            .req     (slot_req[i]),
            .err     (slot_err[i])
        );
    end

    // With both pending, the master not served last wins.
    assign gnt  = (&pend) ? ~last : pend[1];
    assign cur  = slot_req[grant];
    assign free = (state == ST_DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            grant      <= 1'b0;
            last       <= 1'b1;
            timed_out  <= 1'b0;
            cnt        <= '0;
            bus.s_ad   <= '0;
            bus.s_tag  <= '0;
            bus.s_astb <= 1'b0;
            bus.s_rd   <= 1'b0;
            bus.s_wr   <= 1'b0;
            bus.m_data <= '0;
            bus.m_dtag <= '0;
            bus.m_done <= '0;
            bus.m_err  <= '0;
        end else begin
            bus.m_done <= '0;
            bus.m_err  <= slot_err;
            case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        grant      <= gnt;
                        bus.s_astb <= 1'b1;
                        bus.s_ad   <= slot_req[gnt].addr;
                        bus.s_tag  <= slot_req[gnt].tag;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    bus.s_astb <= 1'b0;
                    if (cur.op == OP_WR) begin
                        bus.s_wr  <= 1'b1;
                        bus.s_ad  <= cur.wdata;
                        bus.s_tag <= cur.wtag;
                    end else begin
                        bus.s_rd  <= 1'b1;
                        bus.s_ad  <= '0;
                        bus.s_tag <= '0;
                    end
                    state <= ST_DATA;
                end
                ST_DATA: begin
                    bus.s_rd  <= 1'b0;
                    bus.s_wr  <= 1'b0;
                    bus.s_ad  <= '0;
                    bus.s_tag <= '0;
                    cnt       <= CNT_W'(1);
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.s_rdy) begin
                        timed_out <= 1'b0;
                        if (cur.op == OP_RD) begin
                            bus.m_data <= bus.s_data;
                            bus.m_dtag <= bus.s_dtag;
                        end
                        state <= ST_DONE;
                    end else if (cnt == TIMEOUT_C) begin
                        timed_out  <= 1'b1;
                        bus.m_data <= '0;
                        bus.m_dtag <= '0;
                        state      <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    bus.m_done[grant] <= 1'b1;
                    bus.m_err[grant]  <= slot_err[grant] | timed_out;
                    last              <= grant;
                    timed_out         <= 1'b0;
                    cnt               <= '0;
                    state             <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
